// File: rtl/btn_press_gen.sv
// btn_press_gen: drives a BTN-style line with a programmed train
// of short or long presses, each followed by a fixed release gap.
module btn_press_gen #(
  parameter int CLK_FREQ    = 1_000,
  parameter int SHORT_TICKS = CLK_FREQ / 10,
  parameter int LONG_TICKS  = CLK_FREQ + CLK_FREQ / 4,
  parameter int GAP_TICKS   = CLK_FREQ / 5,
  parameter int COUNT_BITS  = 24
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       KIND,
  input  logic [3:0] REPEAT,
  output logic       BTN_OUT,
  output logic       BUSY,
  output logic       DONE
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [COUNT_BITS-1:0] SHORT_LD =
    COUNT_BITS'(SHORT_TICKS - 1);
  localparam logic [COUNT_BITS-1:0] LONG_LD =
    COUNT_BITS'(LONG_TICKS - 1);
  localparam logic [COUNT_BITS-1:0] GAP_LD =
    COUNT_BITS'(GAP_TICKS - 1);

  state_t                state;
  logic [COUNT_BITS-1:0] cnt;
  logic [3:0]            rem;
  logic                  kind_q;
  logic [COUNT_BITS-1:0] hold_ld;
  logic [COUNT_BITS-1:0] start_ld;
  logic [3:0]            start_rem;

  // Reload value for repeat presses comes from the latched kind;
  // the first press uses the live request inputs.
  assign hold_ld   = kind_q ? LONG_LD : SHORT_LD;
  assign start_ld  = KIND ? LONG_LD : SHORT_LD;
  assign start_rem = (REPEAT == 4'd0) ? 4'd1 : REPEAT;

  // Press-train sequencer; every output is a flop.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= '0;
      rem     <= '0;
      kind_q  <= 1'b0;
      BTN_OUT <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      DONE <= 1'b0;
      unique case (state)
        IDLE: begin
          if (START) begin
            kind_q  <= KIND;
            rem     <= start_rem;
            cnt     <= start_ld;
            state   <= PRESS;
            BTN_OUT <= 1'b1;
            BUSY    <= 1'b1;
          end
        end
        PRESS: begin
          if (cnt == '0) begin
            cnt     <= GAP_LD;
            state   <= GAP;
            BTN_OUT <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            if (rem > 4'd1) begin
              rem     <= rem - 4'd1;
              cnt     <= hold_ld;
              state   <= PRESS;
              BTN_OUT <= 1'b1;
            end else begin
              state <= IDLE;
              BUSY  <= 1'b0;
              DONE  <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          BTN_OUT <= 1'b0;
          BUSY    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_press_gen.sv
// tb_btn_press_gen: directed bench for btn_press_gen with an
// event scoreboard on BTN_OUT edges and DONE pulses.
module tb_btn_press_gen;

  localparam int SHORT = 100;
  localparam int LONG  = 1250;
  localparam int GAPT  = 200;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic       KIND = 1'b0;
  logic [3:0] REPEAT = 4'd0;
  logic       BTN_OUT;
  logic       BUSY;
  logic       DONE;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  logic prev_btn = 1'b0;

  // kind: 0 = rise, 1 = fall, 2 = done pulse
  typedef struct {
    int kind;
    int at;
  } ev_t;
  ev_t sb[$];

  btn_press_gen dut (
    .CLK     (CLK),
    .RST     (RST),
    .START   (START),
    .KIND    (KIND),
    .REPEAT  (REPEAT),
    .BTN_OUT (BTN_OUT),
    .BUSY    (BUSY),
    .DONE    (DONE)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic note(int k);
    ev_t ex;
    if (sb.size() == 0) begin
      chk("unexpected_event", k, -1);
      return;
    end
    ex = sb.pop_front();
    chk("event_kind", k, ex.kind);
    chk("event_cycle", cyc, ex.at);
    if (k == 0) chk("busy_at_rise", BUSY, 1);
    if (k == 2) chk("busy_at_done", BUSY, 0);
  endtask

  always @(negedge CLK) begin
    if (mon_en) begin
      if (BTN_OUT !== prev_btn) begin
        note(BTN_OUT ? 0 : 1);
        prev_btn = BTN_OUT;
      end
      if (DONE === 1'b1) note(2);
    end
  end

  // Called at a negedge; the request is sampled at the next posedge.
  task automatic issue(logic kind, logic [3:0] rep);
    int n;
    int hold;
    int e;
    int p;
    START  = 1'b1;
    KIND   = kind;
    REPEAT = rep;
    e    = cyc + 1;
    n    = (rep == 4'd0) ? 1 : int'(rep);
    hold = kind ? LONG : SHORT;
    p    = hold + GAPT;
    for (int k = 0; k < n; k++) begin
      sb.push_back('{0, e + k * p});
      sb.push_back('{1, e + k * p + hold});
    end
    sb.push_back('{2, e + n * p});
    @(negedge CLK);
    START  = 1'b0;
    KIND   = 1'b0;
    REPEAT = 4'd0;
  endtask

  task automatic wait_done(int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge CLK);
      if (DONE === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_timeout", seen, 1);
  endtask

  initial begin
    // Reset with a START pulse that must be ignored
    RST    = 1'b1;
    START  = 1'b1;
    KIND   = 1'b1;
    REPEAT = 4'd3;
    repeat (3) @(negedge CLK);
    chk("rst_btn", BTN_OUT, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    START  = 1'b0;
    KIND   = 1'b0;
    REPEAT = 4'd0;
    RST    = 1'b0;
    prev_btn = 1'b0;
    mon_en = 1'b1;
    repeat (5) @(negedge CLK);
    chk("post_rst_btn", BTN_OUT, 0);
    chk("post_rst_busy", BUSY, 0);

    // Single short press
    issue(1'b0, 4'd1);
    chk("short_btn", BTN_OUT, 1);
    wait_done(400);
    @(negedge CLK);
    chk("short_done_pulse", DONE, 0);

    // Single long press
    issue(1'b1, 4'd1);
    wait_done(1500);
    @(negedge CLK);
    chk("long_done_pulse", DONE, 0);

    // Three short presses
    issue(1'b0, 4'd3);
    wait_done(1000);
    @(negedge CLK);
    chk("train_done_pulse", DONE, 0);
    chk("train_idle_busy", BUSY, 0);

    // REPEAT=0 acts as one press
    issue(1'b0, 4'd0);
    wait_done(400);
    @(negedge CLK);

    // Request inputs toggled mid-train are ignored
    issue(1'b0, 4'd2);
    repeat (10) @(negedge CLK);
    START  = 1'b1;
    KIND   = 1'b1;
    REPEAT = 4'd9;
    repeat (30) @(negedge CLK);
    START = 1'b0;
    repeat (200) @(negedge CLK);
    START = 1'b1;
    repeat (20) @(negedge CLK);
    START  = 1'b0;
    KIND   = 1'b0;
    REPEAT = 4'd0;
    wait_done(700);
    @(negedge CLK);

    // Back-to-back: START in the DONE cycle
    issue(1'b0, 4'd1);
    wait_done(400);
    issue(1'b0, 4'd1);
    chk("b2b_rise", BTN_OUT, 1);
    chk("b2b_busy", BUSY, 1);
    wait_done(400);
    @(negedge CLK);

    // Reset 40 cycles into a long press
    issue(1'b1, 4'd1);
    repeat (39) @(negedge CLK);
    chk("mid_btn_before", BTN_OUT, 1);
    mon_en = 1'b0;
    sb.delete();
    RST = 1'b1;
    #1;
    chk("mid_rst_btn", BTN_OUT, 0);
    chk("mid_rst_busy", BUSY, 0);
    chk("mid_rst_done", DONE, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    chk("after_rst_btn", BTN_OUT, 0);
    chk("after_rst_busy", BUSY, 0);
    prev_btn = BTN_OUT;
    mon_en = 1'b1;
    issue(1'b0, 4'd1);
    wait_done(400);
    repeat (3) @(negedge CLK);

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
